// File: rtl/switch_allocator.sv
// switch_allocator: control half of a wormhole mesh-router crossbar.
// Snoops flit headers, arbitrates each output round-robin, and holds a
// path from head flit to tail flit so the datapath never sees conflicts.
module switch_allocator #(
    parameter int INPUTS        = 4,
    parameter int OUTPUTS       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int REQUEST_WIDTH = 32,
    parameter int DEST_WIDTH    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [INPUTS*DATA_WIDTH-1:0]      data_in,
    input  logic [INPUTS-1:0]                 valid_in,
    input  logic [OUTPUTS-1:0]                ready_out,
    output logic [OUTPUTS*REQUEST_WIDTH-1:0]  routeSelect,
    output logic [INPUTS*REQUEST_WIDTH-1:0]   inputRoute,
    output logic [OUTPUTS-1:0]                outputBusy,
    output logic [INPUTS-1:0]                 PortReserved,
    output logic [INPUTS-1:0]                 routeError
);

    localparam int IW = (INPUTS  > 1) ? $clog2(INPUTS)  : 1;
    localparam int OW = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

    // Path state: an input is ACTIVE when r_active is set, an output is BUSY when r_busy is set
    logic [INPUTS-1:0]  r_active;
    logic [OUTPUTS-1:0] r_busy;
    logic [INPUTS-1:0]  r_err;
    logic [OW-1:0]      r_route [INPUTS];
    logic [IW-1:0]      r_owner [OUTPUTS];
    logic [IW-1:0]      r_rr    [OUTPUTS];

    logic [1:0]         w_type  [INPUTS];
    logic [31:0]        w_dval  [INPUTS];
    logic [OW-1:0]      w_dest  [INPUTS];
    logic [INPUTS-1:0]  w_req;
    logic [INPUTS-1:0]  w_err;
    logic [INPUTS-1:0]  w_fire;
    logic [INPUTS-1:0]  w_rel;
    logic [OUTPUTS-1:0] w_gnt_vld;
    logic [IW-1:0]      w_gnt    [OUTPUTS];
    logic [IW-1:0]      w_rr_nxt [OUTPUTS];
    logic               w_unused_data;

    // Header bits between the destination field and the type field carry no control meaning
    assign w_unused_data = ^data_in;

    // Decode flit type/destination and classify each input as requesting, erroneous or firing
    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            w_type[i] = data_in[i*DATA_WIDTH + DATA_WIDTH - 2 +: 2];
            w_dval[i] = 32'(data_in[i*DATA_WIDTH +: DEST_WIDTH]);
            w_dest[i] = OW'(w_dval[i]);
            // type[0] set means head (01) or single (11)
            w_req[i]  = !r_active[i] && valid_in[i] && w_type[i][0] &&
                        (w_dval[i] < 32'(OUTPUTS));
            w_err[i]  = !r_active[i] && valid_in[i] &&
                        (!w_type[i][0] || (w_dval[i] >= 32'(OUTPUTS)));
            w_fire[i] = valid_in[i] && r_active[i] && ready_out[r_route[i]];
            // type[1] set means tail (10) or single (11)
            w_rel[i]  = w_fire[i] && w_type[i][1];
        end
    end

    // Round-robin pick per FREE output, scanning from r_rr upward with wrap
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < OUTPUTS; o++) begin
            w_gnt_vld[o] = 1'b0;
            w_gnt[o]     = '0;
            w_rr_nxt[o]  = r_rr[o];
            if (!r_busy[o]) begin
                for (int k = 0; k < INPUTS; k++) begin
                    idx = (int'(r_rr[o]) + k) % INPUTS;
                    if (!w_gnt_vld[o] && w_req[idx] && (w_dest[idx] == OW'(o))) begin
                        w_gnt_vld[o] = 1'b1;
                        w_gnt[o]     = IW'(idx);
                        w_rr_nxt[o]  = IW'((idx + 1) % INPUTS);
                    end
                end
            end
        end
    end

    // Reserve paths on grant, free them after a tail/single transfer, register errors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
            r_busy   <= '0;
            r_err    <= '0;
            for (int i = 0; i < INPUTS; i++) r_route[i] <= '0;
            for (int o = 0; o < OUTPUTS; o++) begin
                r_owner[o] <= '0;
                r_rr[o]    <= '0;
            end
        end else begin
            r_err <= w_err;
            // A releasing input is ACTIVE, so it never collides with a grant below
            for (int i = 0; i < INPUTS; i++) begin
                if (w_rel[i]) begin
                    r_active[i]         <= 1'b0;
                    r_route[i]          <= '0;
                    r_busy[r_route[i]]  <= 1'b0;
                    r_owner[r_route[i]] <= '0;
                end
            end
            // Only FREE outputs grant, so a just-released output waits one cycle
            for (int o = 0; o < OUTPUTS; o++) begin
                if (w_gnt_vld[o]) begin
                    r_busy[o]            <= 1'b1;
                    r_owner[o]           <= w_gnt[o];
                    r_rr[o]              <= w_rr_nxt[o];
                    r_active[w_gnt[o]]   <= 1'b1;
                    r_route[w_gnt[o]]    <= OW'(o);
                end
            end
        end
    end

    // Expose the registered state, indices zero-extended to the select width
    always_comb begin
        for (int o = 0; o < OUTPUTS; o++)
            routeSelect[o*REQUEST_WIDTH +: REQUEST_WIDTH] = REQUEST_WIDTH'(r_owner[o]);
        for (int i = 0; i < INPUTS; i++)
            inputRoute[i*REQUEST_WIDTH +: REQUEST_WIDTH] = REQUEST_WIDTH'(r_route[i]);
    end

    assign outputBusy   = r_busy;
    assign PortReserved = r_active;
    assign routeError   = r_err;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed scoreboard bench for switch_allocator (4x4, 8-bit flits, 3-bit dest field).
module tb_switch_allocator;

    localparam int NI  = 4;
    localparam int NO  = 4;
    localparam int DW  = 8;
    localparam int RW  = 32;
    localparam int DSW = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NI*DW-1:0]    data_in;
    logic [NI-1:0]       valid_in;
    logic [NO-1:0]       ready_out;
    logic [NO*RW-1:0]    routeSelect;
    logic [NI*RW-1:0]    inputRoute;
    logic [NO-1:0]       outputBusy;
    logic [NI-1:0]       PortReserved;
    logic [NI-1:0]       routeError;

    switch_allocator #(
        .INPUTS(NI), .OUTPUTS(NO), .DATA_WIDTH(DW), .REQUEST_WIDTH(RW), .DEST_WIDTH(DSW)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .routeSelect(routeSelect), .inputRoute(inputRoute), .outputBusy(outputBusy),
        .PortReserved(PortReserved), .routeError(routeError)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [3:0]   busy;
        logic [3:0]   res;
        logic [3:0]   err;
        logic [127:0] rs;
        logic [127:0] ir;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] e_busy, e_res, e_err;
    int         e_rs[4];
    int         e_ir[4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic exp_clear();
        e_busy = '0; e_res = '0; e_err = '0;
        for (int k = 0; k < 4; k++) begin
            e_rs[k] = 0;
            e_ir[k] = 0;
        end
    endtask

    task automatic put(input int i, input logic [7:0] f, input logic v);
        data_in[i*DW +: DW] = f;
        valid_in[i]         = v;
    endtask

    // Queue the expected state after the coming edge, then move to the next cycle
    task automatic tick();
        exp_t e;
        e.cyc  = cyc + 1;
        e.busy = e_busy;
        e.res  = e_res;
        e.err  = e_err;
        for (int k = 0; k < 4; k++) begin
            e.rs[k*RW +: RW] = RW'(e_rs[k]);
            e.ir[k*RW +: RW] = RW'(e_ir[k]);
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after each edge, pop and compare the expectation tagged for this cycle
    initial begin
        exp_t m;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                m = q.pop_front();
                if (m.cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL sched: got cycle %0d expected cycle %0d", cyc, m.cyc);
                end
                chk("outputBusy",   {124'd0, outputBusy},   {124'd0, m.busy});
                chk("PortReserved", {124'd0, PortReserved}, {124'd0, m.res});
                chk("routeError",   {124'd0, routeError},   {124'd0, m.err});
                chk("routeSelect",  routeSelect, m.rs);
                chk("inputRoute",   inputRoute,  m.ir);
            end
        end
    end

    initial begin
        rst = 1'b1; data_in = '0; valid_in = '0; ready_out = '1;
        exp_clear();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Basic path: head 42 (dest 2) on input 0, body, tail 80
        put(0, 8'h42, 1'b1);
        e_busy = 4'b0100; e_rs[2] = 0; e_ir[0] = 2; e_res = 4'b0001; tick();
        tick();
        put(0, 8'h00, 1'b1); tick();
        put(0, 8'h80, 1'b1); exp_clear(); tick();
        put(0, 8'h00, 1'b0); tick();

        // Contention: inputs 1 and 3 head to dest 0, rr[0]=0 -> input 1
        put(1, 8'h40, 1'b1); put(3, 8'h40, 1'b1);
        e_busy = 4'b0001; e_rs[0] = 1; e_ir[1] = 0; e_res = 4'b0010; tick();
        tick();
        put(1, 8'h80, 1'b1); exp_clear(); tick();
        put(1, 8'h00, 1'b0);
        e_busy = 4'b0001; e_rs[0] = 3; e_ir[3] = 0; e_res = 4'b1000; tick();
        tick();
        put(3, 8'h80, 1'b1); exp_clear(); tick();
        put(3, 8'h00, 1'b0); tick();
        // rr[0] wrapped to 0: the same contention picks input 1 again
        put(1, 8'h40, 1'b1); put(3, 8'h40, 1'b1);
        e_busy = 4'b0001; e_rs[0] = 1; e_ir[1] = 0; e_res = 4'b0010; tick();
        put(3, 8'h00, 1'b0); tick();
        put(1, 8'h80, 1'b1); exp_clear(); tick();
        put(1, 8'h00, 1'b0); tick();

        // Backpressure: tail held with ready_out[2]=0 for 5 cycles
        put(1, 8'h42, 1'b1);
        e_busy = 4'b0100; e_rs[2] = 1; e_ir[1] = 2; e_res = 4'b0010; tick();
        tick();
        put(1, 8'h80, 1'b1); ready_out = 4'b1011;
        repeat (5) tick();
        ready_out = 4'b1111; exp_clear(); tick();
        put(1, 8'h00, 1'b0); tick();

        // Single flit C1 on input 2, then a head granted at edge 3
        put(2, 8'hC1, 1'b1);
        e_busy = 4'b0010; e_rs[1] = 2; e_ir[2] = 1; e_res = 4'b0100; tick();
        exp_clear(); tick();
        put(2, 8'h43, 1'b1);
        e_busy = 4'b1000; e_rs[3] = 2; e_ir[2] = 3; e_res = 4'b0100; tick();
        tick();
        put(2, 8'h80, 1'b1); exp_clear(); tick();
        put(2, 8'h00, 1'b0); tick();

        // Errors while input 1 holds output 0
        put(1, 8'h40, 1'b1);
        e_busy = 4'b0001; e_rs[0] = 1; e_ir[1] = 0; e_res = 4'b0010; tick();
        put(1, 8'h00, 1'b1); put(0, 8'h00, 1'b1); e_err = 4'b0001; tick();
        put(0, 8'h00, 1'b0); e_err = 4'b0000; tick();
        put(3, 8'h45, 1'b1); e_err = 4'b1000; tick();
        put(3, 8'h00, 1'b0); e_err = 4'b0000; tick();
        put(0, 8'h80, 1'b1); e_err = 4'b0001; tick();
        put(0, 8'h00, 1'b0); e_err = 4'b0000; tick();

        // Second path then a mid-packet reset
        put(2, 8'h43, 1'b1);
        e_busy = 4'b1001; e_rs[3] = 2; e_ir[2] = 3; e_res = 4'b0110; tick();
        rst = 1'b1; exp_clear(); tick();
        rst = 1'b0; put(1, 8'h00, 1'b0);
        e_busy = 4'b1000; e_rs[3] = 2; e_ir[2] = 3; e_res = 4'b0100; tick();
        tick();
        put(2, 8'h80, 1'b1); exp_clear(); tick();
        put(2, 8'h00, 1'b0); tick();

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
